// File: rtl/pps_time_tx.sv
// PPS/time link transmitter: emits a programmable-width PPS pulse, then a
// serial frame (start, NBITS data LSB first, even parity, stop) carrying the new second.
module pps_time_tx #(
   parameter string SYSCLKTYPE = "NONE",
   parameter int    NBITS      = 32
) (
   input  logic             sys_clk_i,
   input  logic             sys_rst_i,
   input  logic             en_i,
   input  logic             pps_flag_i,
   input  logic [NBITS-1:0] cur_sec_i,
   input  logic [15:0]      pulse_width_i,
   input  logic [7:0]       bit_period_i,
   output logic             pps_o,
   output logic             tx_o,
   output logic             busy_o,
   output logic [NBITS-1:0] sec_sent_o,
   output logic             overrun_o,
   output logic [15:0]      overrun_count_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PULSE  = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
      S_PARITY = 3'd4,
      S_STOP   = 3'd5
   } state_t;

   localparam logic [5:0] LP_LAST_IDX = 6'(NBITS - 1);

   function automatic logic f_even_parity(input logic [NBITS-1:0] d);
      return ^d;
   endfunction

   state_t           r_state;
   logic [15:0]      r_pcnt;
   logic [7:0]       r_bcnt;
   logic [5:0]       r_idx;
   logic [NBITS-1:0] r_shift;
   logic             r_par;
   logic [7:0]       r_bp;
   logic             r_pps;
   logic             r_tx;
   logic             r_busy;
   logic [NBITS-1:0] r_sec;
   logic             r_ovr;
   logic [15:0]      r_ovc;

   state_t           w_state;
   logic [15:0]      w_pcnt;
   logic [7:0]       w_bcnt;
   logic [5:0]       w_idx;
   logic [NBITS-1:0] w_shift;
   logic             w_par;
   logic [7:0]       w_bp;
   logic             w_accept;
   logic             w_overrun;
   logic [NBITS-1:0] w_sec_inc;
   logic             w_pps_nxt;
   logic             w_tx_nxt;
   logic             w_busy_nxt;

   assign w_accept  = pps_flag_i & en_i;
   assign w_overrun = w_accept & r_busy;
   assign w_sec_inc = cur_sec_i + NBITS'(1);

   // State and frame datapath registers
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         r_state <= S_IDLE;
         r_pcnt  <= 16'd0;
         r_bcnt  <= 8'd0;
         r_idx   <= 6'd0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_bp    <= 8'd0;
      end else begin
         r_state <= w_state;
         r_pcnt  <= w_pcnt;
         r_bcnt  <= w_bcnt;
         r_idx   <= w_idx;
         r_shift <= w_shift;
         r_par   <= w_par;
         r_bp    <= w_bp;
      end
   end

   // Next state; an accepted flag always restarts the sequence, aborting any frame in flight
   always_comb begin
      w_state = r_state;
      w_pcnt  = r_pcnt;
      w_bcnt  = r_bcnt;
      w_idx   = r_idx;
      w_shift = r_shift;
      w_par   = r_par;
      w_bp    = r_bp;
      if (w_accept) begin
         w_state = S_PULSE;
         w_pcnt  = (pulse_width_i == 16'd0) ? 16'd0 : pulse_width_i - 16'd1;
         w_bp    = bit_period_i;
         w_bcnt  = bit_period_i;
         w_idx   = 6'd0;
         w_shift = w_sec_inc;
         w_par   = f_even_parity(w_sec_inc);
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state = S_IDLE;
            end
            S_PULSE: begin
               if (r_pcnt == 16'd0) begin
                  w_state = S_START;
                  w_bcnt  = r_bp;
               end else begin
                  w_pcnt = r_pcnt - 16'd1;
               end
            end
            S_START: begin
               if (r_bcnt == 8'd0) begin
                  w_state = S_DATA;
                  w_bcnt  = r_bp;
                  w_idx   = 6'd0;
               end else begin
                  w_bcnt = r_bcnt - 8'd1;
               end
            end
            S_DATA: begin
               if (r_bcnt == 8'd0) begin
                  w_bcnt = r_bp;
                  if (r_idx == LP_LAST_IDX) begin
                     w_state = S_PARITY;
                  end else begin
                     w_idx   = r_idx + 6'd1;
                     w_shift = r_shift >> 1;
                  end
               end else begin
                  w_bcnt = r_bcnt - 8'd1;
               end
            end
            S_PARITY: begin
               if (r_bcnt == 8'd0) begin
                  w_state = S_STOP;
                  w_bcnt  = r_bp;
               end else begin
                  w_bcnt = r_bcnt - 8'd1;
               end
            end
            S_STOP: begin
               if (r_bcnt == 8'd0) begin
                  w_state = S_IDLE;
               end else begin
                  w_bcnt = r_bcnt - 8'd1;
               end
            end
            default: begin
               w_state = S_IDLE;
            end
         endcase
      end
   end

   // Line levels for the state about to be entered, so the outputs can be registered
   always_comb begin
      w_pps_nxt  = 1'b0;
      w_tx_nxt   = 1'b1;
      w_busy_nxt = 1'b1;
      case (w_state)
         S_IDLE:   w_busy_nxt = 1'b0;
         S_PULSE:  w_pps_nxt  = 1'b1;
         S_START:  w_tx_nxt   = 1'b0;
         S_DATA:   w_tx_nxt   = w_shift[0];
         S_PARITY: w_tx_nxt   = w_par;
         S_STOP:   w_tx_nxt   = 1'b1;
         default:  w_busy_nxt = 1'b0;
      endcase
   end

   // Registered outputs
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         r_pps  <= 1'b0;
         r_tx   <= 1'b1;
         r_busy <= 1'b0;
         r_sec  <= '0;
         r_ovr  <= 1'b0;
         r_ovc  <= 16'd0;
      end else begin
         r_pps  <= w_pps_nxt;
         r_tx   <= w_tx_nxt;
         r_busy <= w_busy_nxt;
         r_ovr  <= w_overrun;
         if (w_accept) begin
            r_sec <= w_sec_inc;
         end
         if (w_overrun && (r_ovc != 16'hFFFF)) begin
            r_ovc <= r_ovc + 16'd1;
         end
      end
   end

   assign pps_o           = r_pps;
   assign tx_o            = r_tx;
   assign busy_o          = r_busy;
   assign sec_sent_o      = r_sec;
   assign overrun_o       = r_ovr;
   assign overrun_count_o = r_ovc;

endmodule

// File: tb/tb_pps_time_tx.sv
// Bench for pps_time_tx: directed and random frames checked cycle by cycle against
// an expected waveform built from the pulse width, bit period and second value.
module tb_pps_time_tx;

   localparam int NB = 32;

   logic          clk;
   logic          rst;
   logic          en_i;
   logic          flag_i;
   logic [NB-1:0] cur_sec;
   logic [15:0]   pw;
   logic [7:0]    bp;
   logic          pps_o;
   logic          tx_o;
   logic          busy_o;
   logic [NB-1:0] sec_sent_o;
   logic          overrun_o;
   logic [15:0]   overrun_count_o;

   int n_checks = 0;
   int n_errors = 0;
   int exp_ovc  = 0;

   pps_time_tx #(.SYSCLKTYPE("NONE"), .NBITS(NB)) dut (
      .sys_clk_i       (clk),
      .sys_rst_i       (rst),
      .en_i            (en_i),
      .pps_flag_i      (flag_i),
      .cur_sec_i       (cur_sec),
      .pulse_width_i   (pw),
      .bit_period_i    (bp),
      .pps_o           (pps_o),
      .tx_o            (tx_o),
      .busy_o          (busy_o),
      .sec_sent_o      (sec_sent_o),
      .overrun_o       (overrun_o),
      .overrun_count_o (overrun_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " pps"}, 64'(pps_o), 64'd0);
      chk({tag, " tx"}, 64'(tx_o), 64'd1);
      chk({tag, " busy"}, 64'(busy_o), 64'd0);
      chk({tag, " ovr"}, 64'(overrun_o), 64'd0);
   endtask

   // Issue an accepted flag; returns at the first cycle after acceptance
   task automatic start(input logic [NB-1:0] sec, input logic [15:0] w, input logic [7:0] p);
      cur_sec = sec;
      pw      = w;
      bp      = p;
      flag_i  = 1'b1;
      tick();
      flag_i  = 1'b0;
   endtask

   // Expected trace: w cycles of pulse, then NB+3 bits each held (p+1) cycles
   task automatic check_frame(input logic [NB-1:0] sec, input int w, input int p,
                              input int limit, input int en_drop, input string tag);
      logic bits [NB+3];
      int   len;
      logic e_pps;
      logic e_tx;
      bits[0] = 1'b0;
      for (int i = 0; i < NB; i++) bits[i+1] = sec[i];
      bits[NB+1] = ^sec;
      bits[NB+2] = 1'b1;
      len = w + (NB + 3) * (p + 1);
      for (int k = 0; k < len && k < limit; k++) begin
         e_pps = (k < w);
         e_tx  = (k < w) ? 1'b1 : bits[(k - w) / (p + 1)];
         chk($sformatf("%s pps k=%0d", tag, k), 64'(pps_o), 64'(e_pps));
         chk($sformatf("%s tx k=%0d", tag, k), 64'(tx_o), 64'(e_tx));
         chk($sformatf("%s busy k=%0d", tag, k), 64'(busy_o), 64'd1);
         if (k == 0) begin
            chk({tag, " sec_sent"}, 64'(sec_sent_o), 64'(sec));
            pw = 16'($urandom);
            bp = 8'($urandom);
            cur_sec = $urandom;
         end else begin
            chk($sformatf("%s ovr k=%0d", tag, k), 64'(overrun_o), 64'd0);
         end
         if (k == en_drop) en_i = 1'b0;
         flag_i = (en_drop >= 0) && (k == en_drop + 2);
         tick();
      end
      flag_i = 1'b0;
      if (limit >= len) begin
         chk_idle({tag, " end"});
         chk({tag, " ovc"}, 64'(overrun_count_o), 64'(exp_ovc));
      end
      en_i = 1'b1;
   endtask

   initial begin
      logic [NB-1:0] s;
      int            w;
      int            p;
      rst     = 1'b1;
      en_i    = 1'b1;
      flag_i  = 1'b0;
      cur_sec = '0;
      pw      = 16'd0;
      bp      = 8'd0;
      repeat (3) tick();
      chk_idle("reset");
      chk("reset sec_sent", 64'(sec_sent_o), 64'd0);
      chk("reset ovc", 64'(overrun_count_o), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 1000; i++) begin
         chk_idle("idle");
         tick();
      end

      start(32'h0000_0005, 16'd4, 8'd0);
      check_frame(32'h0000_0006, 4, 0, 1000, -1, "dir5");

      start(32'hFFFF_FFFF, 16'd2, 8'd3);
      check_frame(32'h0000_0000, 2, 3, 1000, -1, "wrap");

      start(32'h1234_5678, 16'd0, 8'd1);
      check_frame(32'h1234_5679, 1, 1, 1000, -1, "pw0");

      // Overrun 10 cycles into DATA
      start(32'h0000_0020, 16'd3, 8'd1);
      check_frame(32'h0000_0021, 3, 1, 3 + 2 + 10, -1, "pre_ovr");
      start(32'h0000_0010, 16'd2, 8'd0);
      exp_ovc++;
      chk("ovr pulse", 64'(overrun_o), 64'd1);
      chk("ovr count", 64'(overrun_count_o), 64'(exp_ovc));
      chk("ovr tx", 64'(tx_o), 64'd1);
      chk("ovr pps", 64'(pps_o), 64'd1);
      check_frame(32'h0000_0011, 2, 0, 1000, -1, "post_ovr");

      // Flag on the last STOP cycle is still an overrun
      start(32'h0000_0007, 16'd1, 8'd0);
      check_frame(32'h0000_0008, 1, 0, 1 + 35 - 1, -1, "pre_stop");
      start(32'h8000_0000, 16'd1, 8'd0);
      exp_ovc++;
      chk("stop ovr pulse", 64'(overrun_o), 64'd1);
      chk("stop ovr count", 64'(overrun_count_o), 64'(exp_ovc));
      check_frame(32'h8000_0001, 1, 0, 1000, -1, "post_stop");

      en_i   = 1'b0;
      flag_i = 1'b1;
      tick();
      flag_i = 1'b0;
      for (int i = 0; i < 40; i++) begin
         chk_idle("en0");
         tick();
      end
      en_i = 1'b1;

      start(32'h00C3_A50F, 16'd3, 8'd2);
      check_frame(32'h00C3_A510, 3, 2, 1000, 20, "endrop");

      for (int r = 0; r < 8; r++) begin
         s = $urandom;
         w = $urandom_range(0, 5);
         p = $urandom_range(0, 3);
         start(s, 16'(w), 8'(p));
         check_frame(s + 32'd1, (w == 0) ? 1 : w, p, 1000, -1, $sformatf("rnd%0d", r));
         repeat ($urandom_range(0, 4)) begin
            chk_idle("gap");
            tick();
         end
      end

      // Asynchronous reset in the middle of DATA
      start(32'hA5A5_A5A5, 16'd2, 8'd2);
      check_frame(32'hA5A5_A5A6, 2, 2, 2 + 3 + 20, -1, "pre_rst");
      rst = 1'b1;
      #1;
      chk_idle("arst");
      chk("arst sec_sent", 64'(sec_sent_o), 64'd0);
      chk("arst ovc", 64'(overrun_count_o), 64'd0);
      exp_ovc = 0;
      tick();
      rst = 1'b0;
      tick();
      start(32'h0000_00FF, 16'd1, 8'd0);
      check_frame(32'h0000_0100, 1, 0, 1000, -1, "after_rst");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
